// File: rtl/io_pkg.sv
// Shared types and helpers for the button-event conditioning block.
package io_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/io_button_events_if.sv
// Pin-side levels in, single-cycle clock-domain events out.
interface io_button_events_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] buttons;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] button_pulse;
    logic [N_CH-1:0] button_release;
    logic [N_CH-1:0] button_held;

    modport master (
        output buttons, repeat_en,
        input  button_pulse, button_release, button_held
    );

    modport slave (
        input  buttons, repeat_en,
        output button_pulse, button_release, button_held
    );
endinterface

// File: rtl/io_button_channel.sv
// One button channel: synchroniser, debounce filter, press/release edges
// and hold-to-repeat pulse train.
module io_button_channel
    import io_pkg::*;
#(
    parameter int SYNC_LEN      = 2,
    parameter int DEBOUNCE_CYC  = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    input  logic repeat_en,
    output logic pulse,
    output logic rel,
    output logic held
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW   = cnt_w(DEBOUNCE_CYC);
    localparam int RW   = cnt_w(RMAX);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] RDLY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPER  = RW'(REPEAT_PERIOD);

    logic [SYNC_LEN-1:0] sync_q, sync_d;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic [RW-1:0]       rcnt_q, rcnt_d;
    logic                held_q, held_d;
    logic                pulse_q, pulse_d;
    logic                rel_q, rel_d;
    rpt_state_e          state_q, state_d;
    logic                sync_s, rise, fall, fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            held_q  <= 1'b0;
            pulse_q <= 1'b0;
            rel_q   <= 1'b0;
            state_q <= RPT_IDLE;
        end else begin
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[SYNC_LEN-2:0], button};
        sync_s  = sync_q[SYNC_LEN-1];
        held_d  = held_q;
        dcnt_d  = '0;
        rise    = 1'b0;
        fall    = 1'b0;
        fire    = 1'b0;
        state_d = state_q;
        rcnt_d  = rcnt_q;

        // Any sample agreeing with the held level restarts the mismatch count.
        if (sync_s != held_q) begin
            if (dcnt_q == DLAST) begin
                held_d = sync_s;
                rise   = sync_s;
                fall   = !sync_s;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end

        // A release or a dropped enable silences any repeat due this cycle.
        if (fall || !repeat_en) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
        end else begin
            unique case (state_q)
                RPT_IDLE: begin
                    if (rise || held_q) begin
                        state_d = RPT_DELAY;
                        rcnt_d  = RW'(1);
                    end
                end
                RPT_DELAY: begin
                    if (rcnt_q == RDLY) begin
                        fire    = 1'b1;
                        state_d = RPT_REPEAT;
                        rcnt_d  = RW'(1);
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt_q == RPER) begin
                        fire   = 1'b1;
                        rcnt_d = RW'(1);
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        pulse_d = rise | fire;
        rel_d   = fall;
    end

    assign pulse = pulse_q;
    assign rel   = rel_q;
    assign held  = held_q;

endmodule

// File: rtl/io_button_events.sv
// N_CH independent button conditioners turning raw pin levels into
// debounced levels and single-cycle press/release/repeat pulses.
module io_button_events
    import io_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SYNC_LEN      = 2,
    parameter int DEBOUNCE_CYC  = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    io_button_events_if.slave   bus
);
    logic [N_CH-1:0] pulse_w, rel_w, held_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        io_button_channel #(
            .SYNC_LEN      (SYNC_LEN),
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .button    (bus.buttons[i]),
            .repeat_en (bus.repeat_en[i]),
            .pulse     (pulse_w[i]),
            .rel       (rel_w[i]),
            .held      (held_w[i])
        );
    end

    assign bus.button_pulse   = pulse_w;
    assign bus.button_release = rel_w;
    assign bus.button_held    = held_w;

endmodule

// File: tb/tb_io_button_events.sv
// Scoreboard bench for io_button_events: stimulus queues expected pulse/release
// events with their cycle numbers, a monitor pops and compares them.
module tb_io_button_events;
    localparam int L = 5;  // input change before edge k -> event after edge k+L

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   c;
    ev_t  q[$];

    io_button_events_if #(.N_CH(4)) bus ();

    io_button_events #(
        .N_CH(4), .SYNC_LEN(2), .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic [3:0] p, input logic [3:0] r);
        ev_t e;
        e.cyc = at; e.p = p; e.r = r;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle with any pulse or release must match the next queued event.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n === 1'b1 && (bus.button_pulse !== 4'b0 || bus.button_release !== 4'b0)) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event cyc=%0d pulse=%b release=%b expected none",
                         cyc, bus.button_pulse, bus.button_release);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.p !== bus.button_pulse || e.r !== bus.button_release) begin
                    fails++;
                    $display("FAIL event got cyc=%0d pulse=%b release=%b expected cyc=%0d pulse=%b release=%b",
                             cyc, bus.button_pulse, bus.button_release, e.cyc, e.p, e.r);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.buttons   = 4'b0;
        bus.repeat_en = 4'b0;
        step(3);
        chk("reset_held", bus.button_held, 4'b0);
        chk("reset_pulse", bus.button_pulse, 4'b0);
        chk("reset_release", bus.button_release, 4'b0);
        rst_n = 1'b1;
        step(3);

        // Single press / release on channel 0, no repeat.
        c = cyc;
        bus.buttons[0] = 1'b1;
        push(c + 1 + L, 4'b0001, 4'b0000);
        step(L);
        chk("s1_held_before", bus.button_held, 4'b0000);
        step(1);
        chk("s1_held_after", bus.button_held, 4'b0001);
        step(4);
        c = cyc;
        bus.buttons[0] = 1'b0;
        push(c + 1 + L, 4'b0000, 4'b0001);
        step(10);
        chk("s1_held_released", bus.button_held, 4'b0000);

        // 3-cycle glitch rejected, 4-cycle glitch accepted.
        bus.buttons[1] = 1'b1;
        step(3);
        bus.buttons[1] = 1'b0;
        step(12);
        chk("s2_glitch3_held", bus.button_held, 4'b0000);
        c = cyc;
        bus.buttons[1] = 1'b1;
        push(c + 6, 4'b0010, 4'b0000);
        push(c + 10, 4'b0000, 4'b0010);
        step(4);
        bus.buttons[1] = 1'b0;
        step(12);

        // Auto-repeat on channel 2, released before the 6th repeat falls due.
        c = cyc;
        bus.repeat_en[2] = 1'b1;
        bus.buttons[2]   = 1'b1;
        push(c + 6, 4'b0100, 4'b0000);
        for (int n = 0; n < 5; n++) push(c + 26 + 8 * n, 4'b0100, 4'b0000);
        push(c + 64, 4'b0000, 4'b0100);
        step(30);
        chk("s3_held_mid", bus.button_held, 4'b0100);
        step(28);
        bus.buttons[2] = 1'b0;
        step(15);
        bus.repeat_en[2] = 1'b0;

        // Channel 3: enable raised mid-hold, dropped on a due repeat.
        c = cyc;
        bus.buttons[3] = 1'b1;
        push(c + 6, 4'b1000, 4'b0000);
        push(c + 37, 4'b1000, 4'b0000);
        push(c + 45, 4'b1000, 4'b0000);
        push(c + 53, 4'b1000, 4'b0000);
        push(c + 81, 4'b0000, 4'b1000);
        step(16);
        bus.repeat_en[3] = 1'b1;
        step(44);
        bus.repeat_en[3] = 1'b0;
        step(15);
        bus.buttons[3] = 1'b0;
        step(15);

        // All channels together; channel 0 released on a due repeat.
        c = cyc;
        bus.repeat_en = 4'b0001;
        bus.buttons   = 4'b1111;
        push(c + 6, 4'b1111, 4'b0000);
        push(c + 26, 4'b0001, 4'b0000);
        push(c + 34, 4'b0001, 4'b0000);
        push(c + 42, 4'b0000, 4'b0001);
        push(c + 51, 4'b0000, 4'b1110);
        step(36);
        bus.buttons[0] = 1'b0;
        step(9);
        bus.buttons = 4'b0000;
        step(12);
        chk("s5_held_all_released", bus.button_held, 4'b0000);
        bus.repeat_en = 4'b0000;

        // Reset during a repeat train with the button kept down.
        c = cyc;
        bus.repeat_en[2] = 1'b1;
        bus.buttons[2]   = 1'b1;
        push(c + 6, 4'b0100, 4'b0000);
        push(c + 26, 4'b0100, 4'b0000);
        step(30);
        chk("s6_held_pre_reset", bus.button_held, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("s6_reset_held", bus.button_held, 4'b0000);
        chk("s6_reset_pulse", bus.button_pulse, 4'b0000);
        chk("s6_reset_release", bus.button_release, 4'b0000);
        step(3);
        c = cyc;
        rst_n = 1'b1;
        push(c + 1 + L, 4'b0100, 4'b0000);
        push(c + 1 + L + 20, 4'b0100, 4'b0000);
        step(L);
        chk("s6_held_before_repress", bus.button_held, 4'b0000);
        step(23);
        bus.buttons[2] = 1'b0;
        push(cyc + 1 + L, 4'b0000, 4'b0100);
        step(12);
        bus.repeat_en[2] = 1'b0;
        step(2);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_events remaining=%0d expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_button_events.md
Name: io_button_events

Overview:
- Parametrised successor to the basic pulse generator: conditions N_CH raw asynchronous button/switch inputs into clean, clock-domain events.
- Each channel has a SYNC_LEN-stage synchroniser, a debounce filter, press and release one-cycle pulses, and an optional hold-to-auto-repeat pulse train.
- Sits between board pins (KEY/SW) and the composition control FSMs, which consume single-cycle pulses only.

Parameters:
- N_CH, 4, number of independent channels.
- SYNC_LEN, 2, synchroniser flop stages (>=2).
- DEBOUNCE_CYC, 4, consecutive mismatching synchronised samples needed to accept a level change (>=1; 1 means no filtering).
- REPEAT_DELAY, 20, cycles from press pulse to first repeat pulse (>=1).
- REPEAT_PERIOD, 8, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- buttons  in  N_CH  raw button levels, active-high, asynchronous to clk.
- repeat_en  in  N_CH  per-channel auto-repeat enable, synchronous to clk.
- button_pulse  out  N_CH  one-cycle pulse on accepted press, and on each auto-repeat.
- button_release  out  N_CH  one-cycle pulse on accepted release.
- button_held  out  N_CH  debounced stable level.

Behaviour:
- Reset (async assert, sync-released use): all sync flops, stable levels, counters and outputs are 0.
- Synchroniser: s[i] is buttons[i] delayed SYNC_LEN edges. No logic between stages.
- Debounce, per channel:
  - Counter dcnt, width $clog2(DEBOUNCE_CYC+1).
  - If s == held, dcnt <= 0.
  - Else, if dcnt == DEBOUNCE_CYC-1: held <= s and dcnt <= 0. Otherwise dcnt <= dcnt+1.
  - A mismatch shorter than DEBOUNCE_CYC consecutive samples is discarded with no output.
- Press/release: button_pulse and button_release are registered outputs.
  - They assert on the same edge that held changes 0->1 or 1->0, for exactly one cycle.
  - Latency: buttons stable before edge k -> held and pulse visible after edge k+SYNC_LEN+DEBOUNCE_CYC-1.
- Auto-repeat, per channel:
  - Counter rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on the press edge, only if repeat_en[i]=1. rcnt <= 1.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY: button_pulse=1 for one cycle, rcnt <= 1, go to REPEAT.
  - REPEAT: when rcnt == REPEAT_PERIOD: pulse, rcnt <= 1. Otherwise rcnt increments.
  - Any state -> IDLE (rcnt <= 0) when held falls or repeat_en[i]=0. No pulse is emitted on that cycle.
  - repeat_en rising while held=1 in IDLE: go to DELAY with rcnt <= 1 (delay restarts from that edge).
  - Result: if press pulse is at cycle P, repeats occur at P+REPEAT_DELAY+n*REPEAT_PERIOD, n>=0.
- Simultaneous events: channels are fully independent. A release edge takes precedence over a repeat due on the same cycle; button_pulse=0 and button_release=1.
- Reset mid-operation: everything clears immediately. If a button is still held at reset release, it produces a fresh press pulse after the full latency (held restarts at 0).
- No combinational path from any input to any output.

Decomposition:
- Package io_pkg: typedef for the repeat FSM state enum (RPT_IDLE, RPT_DELAY, RPT_REPEAT), plus a width helper function cnt_w(n) = $clog2(n+1).
- Sub-module io_button_channel holds one channel: sync chain, debounce, edge and repeat logic.
- The top instantiates N_CH copies in a generate loop.

Test Plan:
- Single press, defaults (SYNC_LEN=2, DEBOUNCE_CYC=4): buttons[0] rises before edge 10 and stays high. button_held[0] and button_pulse[0] go high after edge 15; the pulse is 1 cycle; other channels stay 0.
- Glitch rejection: buttons[1] high for 3 cycles, then low. No pulse, no release, held stays 0. Repeat with a 4-cycle glitch -> press pulse then release pulse 4 cycles later.
- Auto-repeat: repeat_en[2]=1, hold button 60 cycles, press pulse at P. Repeats at P+20, P+28, P+36 ... while held. On release: button_release pulse and no further repeats.
- repeat_en control: hold with repeat_en[3]=0 -> only the press pulse. Assert repeat_en[3] at cycle Q -> first repeat at Q+20. Deassert mid-train -> pulses stop on that cycle.
- Simultaneous channels: all 4 buttons rise on the same edge -> all 4 press pulses on the same cycle. Release channel 0 exactly on a due repeat -> release=1, pulse=0.
- Reset mid-hold: assert rst_n=0 during a repeat train -> all outputs 0 immediately. Release reset with button still high -> new press pulse SYNC_LEN+DEBOUNCE_CYC edges later.
